fft64_frame_sched: RTL and testbench

- Frame-level scheduler feeding the fft64 core from two independent complex-sample sources.
- Each source streams samples into its own 64-entry frame buffer using a valid/ready handshake.
- Round-robin arbitration picks a full buffer and bursts it to fft64 as exactly 64 contiguous din_valid cycles.
- The block then tags each 64-beat fft64 output frame with the channel that produced it.

---
 rtl/fft64_frame_sched.sv | 210 +++++++++++++++++++++
 tb/tb_fft64_frame_sched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft64_frame_sched.sv
// Frame scheduler: buffers two complex sample streams into 64-entry frames,
// bursts full frames to fft64 round-robin, and tags returning fft64 frames
// with their source channel.
module fft64_frame_sched #(
    parameter int unsigned DW      = 10,
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned GAP     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s0_valid,
    output logic          s0_ready,
    input  logic [DW-1:0] s0_re,
    input  logic [DW-1:0] s0_im,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  logic [DW-1:0] s1_re,
    input  logic [DW-1:0] s1_im,
    output logic [DW-1:0] fft_din_re,
    output logic [DW-1:0] fft_din_im,
    output logic          fft_din_valid,
    input  logic          fft_dout_valid,
    output logic          out_chan,
    output logic          out_last,
    output logic          busy,
    output logic          err
);

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;
    localparam int unsigned SW    = 2 * DW;
    localparam int unsigned OW    = 3;
    localparam int unsigned GW    = 4;
    localparam int unsigned TD    = 4;
    localparam int unsigned TPW   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Frame buffers and write side
    logic [SW-1:0] mem0 [DEPTH];
    logic [SW-1:0] mem1 [DEPTH];
    logic [AW-1:0] wptr0_q, wptr1_q;
    logic          full0_q, full1_q;
    logic          wr0_c, wr1_c;
    logic          clr0_c, clr1_c;

    // Arbiter / burst state
    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          din_valid_q, din_valid_d;
    logic [DW-1:0] din_re_q, din_re_d;
    logic [DW-1:0] din_im_q, din_im_d;
    logic          push_c;
    logic          gsel_c;
    logic [SW-1:0] rd_word_c;

    // Output tagging
    logic [OW-1:0]  outstanding_q, outstanding_d;
    logic [AW-1:0]  beat_q;
    logic           err_q;
    logic           tag_q [TD];
    logic [TPW-1:0] tag_wptr_q, tag_rptr_q;
    logic           beat_ok_c, pop_c, stray_c;

    assign s0_ready = ~full0_q;
    assign s1_ready = ~full1_q;
    assign wr0_c    = s0_valid & ~full0_q;
    assign wr1_c    = s1_valid & ~full1_q;

    // Write pointers and full flags; a burst finishing clears its flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr0_q <= '0;
            wptr1_q <= '0;
            full0_q <= 1'b0;
            full1_q <= 1'b0;
        end else begin
            if (wr0_c) begin
                wptr0_q <= wptr0_q + AW'(1);
                if (wptr0_q == AW'(DEPTH - 1)) full0_q <= 1'b1;
            end else if (clr0_c) begin
                full0_q <= 1'b0;
            end
            if (wr1_c) begin
                wptr1_q <= wptr1_q + AW'(1);
                if (wptr1_q == AW'(DEPTH - 1)) full1_q <= 1'b1;
            end else if (clr1_c) begin
                full1_q <= 1'b0;
            end
        end
    end

    // Sample storage (contents are don't-care after reset)
    always_ff @(posedge clk) begin
        if (wr0_c) mem0[wptr0_q] <= {s0_re, s0_im};
        if (wr1_c) mem1[wptr1_q] <= {s1_re, s1_im};
    end

    assign rd_word_c = grant_q ? mem1[addr_q] : mem0[addr_q];

    // Arbiter state and burst output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            gap_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            din_valid_q  <= 1'b0;
            din_re_q     <= '0;
            din_im_q     <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            gap_q        <= gap_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            din_valid_q  <= din_valid_d;
            din_re_q     <= din_re_d;
            din_im_q     <= din_im_d;
        end
    end

    // Next-state: grant a full buffer, stream 64 words, then hold off GAP cycles
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        gap_d        = gap_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        din_valid_d  = 1'b0;
        din_re_d     = din_re_q;
        din_im_d     = din_im_q;
        push_c       = 1'b0;
        gsel_c       = 1'b0;
        clr0_c       = 1'b0;
        clr1_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((full0_q | full1_q) && (outstanding_q < OW'(MAX_OUT))) begin
                    gsel_c       = (full0_q & full1_q) ? ~last_grant_q : full1_q;
                    grant_d      = gsel_c;
                    last_grant_d = gsel_c;
                    push_c       = 1'b1;
                    addr_d       = '0;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                din_valid_d = 1'b1;
                din_re_d    = rd_word_c[SW-1:DW];
                din_im_d    = rd_word_c[DW-1:0];
                addr_d      = addr_q + AW'(1);
                if (addr_q == AW'(DEPTH - 1)) begin
                    clr0_c  = ~grant_q;
                    clr1_c  = grant_q;
                    gap_d   = '0;
                    state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(GAP - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign beat_ok_c     = fft_dout_valid & (outstanding_q != '0);
    assign pop_c         = beat_ok_c & (beat_q == AW'(DEPTH - 1));
    assign stray_c       = fft_dout_valid & (outstanding_q == '0);
    assign outstanding_d = outstanding_q + OW'(push_c) - OW'(pop_c);

    // Tag FIFO, outstanding count, beat counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            beat_q        <= '0;
            err_q         <= 1'b0;
            tag_wptr_q    <= '0;
            tag_rptr_q    <= '0;
            for (int i = 0; i < int'(TD); i++) tag_q[i] <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            err_q         <= err_q | stray_c;
            if (beat_ok_c) beat_q <= beat_q + AW'(1);
            if (push_c) begin
                tag_q[tag_wptr_q] <= gsel_c;
                tag_wptr_q        <= tag_wptr_q + TPW'(1);
            end
            if (pop_c) tag_rptr_q <= tag_rptr_q + TPW'(1);
        end
    end

    assign fft_din_valid = din_valid_q;
    assign fft_din_re    = din_re_q;
    assign fft_din_im    = din_im_q;
    assign out_chan      = tag_q[tag_rptr_q];
    assign out_last      = pop_c;
    assign err           = err_q;
    assign busy          = (state_q != ST_IDLE) | (outstanding_q != '0);

endmodule

// File: tb/tb_fft64_frame_sched.sv
// Directed bench for fft64_frame_sched: buffering, arbitration, throttling,
// output tagging, error flag and mid-burst reset.
module tb_fft64_frame_sched;

    localparam int unsigned DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s0_valid = 1'b0, s1_valid = 1'b0;
    logic          s0_ready, s1_ready;
    logic [DW-1:0] s0_re = '0, s0_im = '0, s1_re = '0, s1_im = '0;
    logic [DW-1:0] fft_din_re, fft_din_im;
    logic          fft_din_valid;
    logic          fft_dout_valid = 1'b0;
    logic          out_chan, out_last, busy, err;

    int total = 0;
    int bad   = 0;

    // Burst monitor state (cleared while rst is high)
    int                vcnt = 0;
    int                cur_run = 0;
    int                zrun = 0;
    logic              prev_v = 1'b0;
    int                starts[$];
    int                runs[$];
    int                gaps[$];
    logic [2*DW-1:0]   data[$];

    fft64_frame_sched #(.DW(DW), .MAX_OUT(2), .GAP(4)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_re(s0_re), .s0_im(s0_im),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_re(s1_re), .s1_im(s1_im),
        .fft_din_re(fft_din_re), .fft_din_im(fft_din_im), .fft_din_valid(fft_din_valid),
        .fft_dout_valid(fft_dout_valid), .out_chan(out_chan), .out_last(out_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Record burst starts, run lengths, idle gaps and data on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            vcnt = 0; cur_run = 0; zrun = 0; prev_v = 1'b0;
            starts.delete(); runs.delete(); gaps.delete(); data.delete();
        end else begin
            if (fft_din_valid) begin
                if (!prev_v) begin
                    starts.push_back(int'(fft_din_re));
                    if (vcnt > 0) gaps.push_back(zrun);
                end
                data.push_back({fft_din_re, fft_din_im});
                vcnt++; cur_run++; zrun = 0;
            end else begin
                if (prev_v) begin runs.push_back(cur_run); cur_run = 0; end
                zrun++;
            end
            prev_v = fft_din_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; fft_dout_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Stream n0 samples into ch0 (re=b0+k, im=-(b0+k)) and n1 into ch1 concurrently
    task automatic write_frames(input int b0, input int b1, input int n0, input int n1);
        int  k0 = 0, k1 = 0, cyc = 0;
        bit  a0, a1;
        while ((k0 < n0 || k1 < n1) && cyc < 2000) begin
            s0_valid = (k0 < n0); s0_re = DW'(b0 + k0); s0_im = DW'(-(b0 + k0));
            s1_valid = (k1 < n1); s1_re = DW'(b1 + k1); s1_im = DW'(-(b1 + k1));
            a0 = s0_valid & s0_ready;
            a1 = s1_valid & s1_ready;
            @(posedge clk); #1;
            cyc++;
            if (a0) k0++;
            if (a1) k1++;
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        total++;
        if (k0 < n0 || k1 < n1) begin
            bad++;
            $display("FAIL write_frames: accepted ch0=%0d/%0d ch1=%0d/%0d", k0, n0, k1, n1);
        end
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (!fft_din_valid && n < maxc) begin @(posedge clk); #1; n++; end
        total++;
        if (fft_din_valid !== 1'b1) begin
            bad++; $display("FAIL wait_valid: no burst within %0d cycles", maxc);
        end
    endtask

    task automatic wait_vcnt(input int target, input int maxc);
        int n = 0;
        while (vcnt < target && n < maxc) begin @(posedge clk); #1; n++; end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (vcnt != target) begin
            bad++; $display("FAIL wait_vcnt: valid beats=%0d expected %0d", vcnt, target);
        end
    endtask

    task automatic drive_dout(input int n);
        for (int i = 0; i < n; i++) begin
            fft_dout_valid = 1'b1;
            @(posedge clk); #1;
        end
        fft_dout_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b1 || fft_din_valid !== 1'b0 ||
            fft_din_re !== '0 || fft_din_im !== '0 || busy !== 1'b0 || err !== 1'b0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset: rdy=%b%b dv=%b re=%0d im=%0d busy=%b err=%b last=%b, want 11 0 0 0 0 0 0",
                     s0_ready, s1_ready, fft_din_valid, fft_din_re, fft_din_im, busy, err, out_last);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        write_frames(0, 0, 64, 0);
        total++;
        if (s0_ready !== 1'b0) begin bad++; $display("FAIL single_ready_low: got %b want 0", s0_ready); end
        wait_valid(10);
        for (int i = 0; i < 64; i++) begin
            total++;
            if (fft_din_valid !== 1'b1 || fft_din_re !== DW'(i) || fft_din_im !== DW'(-i)) begin
                bad++;
                $display("FAIL single_beat %0d: dv=%b re=%0d im=%0d want 1 %0d %0d",
                         i, fft_din_valid, fft_din_re, fft_din_im, DW'(i), DW'(-i));
            end
            if (i == 0) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
            end
            if (i == 62) begin
                total++;
                if (s0_ready !== 1'b0) begin bad++; $display("FAIL single_ready_b62: got %b want 0", s0_ready); end
            end
            if (i == 63) begin
                total++;
                if (s0_ready !== 1'b1) begin bad++; $display("FAIL single_ready_b63: got %b want 1", s0_ready); end
            end
            @(posedge clk); #1;
        end
        total++;
        if (fft_din_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL single_after: dv=%b busy=%b want 0 1", fft_din_valid, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (runs.size() != 1 || vcnt != 64) begin
            bad++; $display("FAIL single_runs: bursts=%0d beats=%0d want 1 64", runs.size(), vcnt);
        end
    endtask

    task automatic test_tie();
        do_reset();
        write_frames(0, 100, 64, 64);
        wait_vcnt(128, 300);
        total++;
        if (starts.size() != 2 || starts[0] != 0 || starts[1] != 100) begin
            bad++; $display("FAIL tie_order: n=%0d first=%0d second=%0d want 2 0 100",
                            starts.size(), starts[0], starts[1]);
        end
        total++;
        if (runs.size() != 2 || runs[0] != 64 || runs[1] != 64) begin
            bad++; $display("FAIL tie_runs: n=%0d r0=%0d r1=%0d want 2 64 64", runs.size(), runs[0], runs[1]);
        end
        // GAP cycles in the GAP state plus one IDLE grant cycle
        total++;
        if (gaps.size() != 1 || gaps[0] != 5) begin
            bad++; $display("FAIL tie_gap: n=%0d gap=%0d want 1 5", gaps.size(), gaps[0]);
        end
        for (int i = 0; i < 128; i++) begin
            total++;
            if (data[i] !== {DW'(i < 64 ? i : i + 36), DW'(i < 64 ? -i : -(i + 36))}) begin
                bad++; $display("FAIL tie_data %0d: got %h want %h", i, data[i],
                                {DW'(i < 64 ? i : i + 36), DW'(i < 64 ? -i : -(i + 36))});
            end
        end
        drive_dout(128);
        write_frames(200, 300, 64, 64);
        wait_vcnt(256, 300);
        total++;
        if (starts.size() != 4 || starts[2] != 200 || starts[3] != 300) begin
            bad++; $display("FAIL tie_second: n=%0d third=%0d fourth=%0d want 4 200 300",
                            starts.size(), starts[2], starts[3]);
        end
    endtask

    task automatic test_throttle();
        int n = 0;
        do_reset();
        write_frames(0, 100, 64, 64);
        write_frames(200, 0, 64, 0);
        repeat (60) @(posedge clk);
        #1;
        total++;
        if (vcnt != 128 || starts.size() != 2 || busy !== 1'b1 || s0_ready !== 1'b0) begin
            bad++; $display("FAIL throttle_hold: beats=%0d bursts=%0d busy=%b rdy0=%b want 128 2 1 0",
                            vcnt, starts.size(), busy, s0_ready);
        end
        for (int i = 0; i < 64; i++) begin
            fft_dout_valid = 1'b1;
            #1;
            if (i == 63) begin
                total++;
                if (out_last !== 1'b1 || out_chan !== 1'b0) begin
                    bad++; $display("FAIL throttle_last: last=%b chan=%b want 1 0", out_last, out_chan);
                end
            end
            @(posedge clk); #1;
        end
        fft_dout_valid = 1'b0;
        while (!fft_din_valid && n < 10) begin @(posedge clk); #1; n++; end
        total++;
        if (n != 2) begin bad++; $display("FAIL throttle_resume: cycles=%0d want 2", n); end
        wait_vcnt(192, 100);
        total++;
        if (starts.size() != 3 || starts[2] != 200) begin
            bad++; $display("FAIL throttle_third: n=%0d start=%0d want 3 200", starts.size(), starts[2]);
        end
    endtask

    task automatic test_tagging();
        bit exp_chan, exp_last;
        do_reset();
        write_frames(0, 100, 0, 64);
        write_frames(0, 0, 64, 0);
        wait_vcnt(128, 300);
        total++;
        if (starts.size() != 2 || starts[0] != 100 || starts[1] != 0) begin
            bad++; $display("FAIL tag_order: n=%0d first=%0d second=%0d want 2 100 0",
                            starts.size(), starts[0], starts[1]);
        end
        for (int i = 0; i < 128; i++) begin
            fft_dout_valid = 1'b1;
            #1;
            exp_chan = (i < 64);
            exp_last = (i == 63) || (i == 127);
            total++;
            if (out_chan !== exp_chan || out_last !== exp_last) begin
                bad++; $display("FAIL tag_beat %0d: chan=%b last=%b want %b %b",
                                i, out_chan, out_last, exp_chan, exp_last);
            end
            @(posedge clk); #1;
        end
        fft_dout_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL tag_after: busy=%b err=%b want 0 0", busy, err);
        end
    endtask

    task automatic test_err();
        do_reset();
        fft_dout_valid = 1'b1;
        #1;
        total++;
        if (out_last !== 1'b0) begin bad++; $display("FAIL err_last: got %b want 0", out_last); end
        @(posedge clk); #1;
        fft_dout_valid = 1'b0;
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL err_set: err=%b busy=%b want 1 0", err, busy);
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
        do_reset();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        write_frames(0, 400, 64, 10);
        wait_valid(10);
        repeat (30) @(posedge clk);
        #1;
        total++;
        if (fft_din_valid !== 1'b1 || fft_din_re !== DW'(30)) begin
            bad++; $display("FAIL midrst_beat30: dv=%b re=%0d want 1 30", fft_din_valid, fft_din_re);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (fft_din_valid !== 1'b0 || s0_ready !== 1'b1 || s1_ready !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_state: dv=%b rdy=%b%b err=%b busy=%b want 0 11 0 0",
                            fft_din_valid, s0_ready, s1_ready, err, busy);
        end
        rst = 1'b0;
        write_frames(0, 300, 0, 64);
        wait_vcnt(64, 200);
        total++;
        if (starts.size() != 1 || starts[0] != 300 || data[63] !== {DW'(363), DW'(-363)}) begin
            bad++; $display("FAIL midrst_new: n=%0d first=%0d last=%h want 1 300 %h",
                            starts.size(), starts[0], data[63], {DW'(363), DW'(-363)});
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_tie();
        test_throttle();
        test_tagging();
        test_err();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
